// File: rtl/dff_shift_ctrl_if.sv
// Handshake and data bundle for the serial-load flip-flop bank.
// The master drives the frame controls; the slave returns the parallel bank and status.
interface dff_shift_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             abort;
    logic             d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, d,
        input  q, qb, busy, done
    );

    modport slave (
        input  start, abort, d,
        output q, qb, busy, done
    );
endinterface

// File: rtl/dff_shift_ctrl.sv
// Serial-to-parallel flip-flop bank: shifts WIDTH bits LSB-first into a shadow
// register and publishes them to q only when a complete frame has been captured.
module dff_shift_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    dff_shift_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] shadow, shadow_nxt;
    logic [WIDTH-1:0] q, q_nxt;
    logic [WIDTH-1:0] bit_mask;

    assign bit_mask = WIDTH'(1) << cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= IDLE;
            cnt    <= '0;
            shadow <= '0;
            q      <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            shadow <= shadow_nxt;
            q      <= q_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        shadow_nxt = shadow;
        q_nxt      = q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt  = SHIFT;
                    cnt_nxt    = '0;
                    shadow_nxt = '0;
                end
            end
            SHIFT: begin
                // Abort wins even on the final bit, so the completed shadow is dropped.
                if (bus.abort) begin
                    state_nxt  = IDLE;
                    cnt_nxt    = '0;
                    shadow_nxt = '0;
                end else begin
                    shadow_nxt = bus.d ? (shadow | bit_mask) : (shadow & ~bit_mask);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state_nxt = DONE;
                        cnt_nxt   = '0;
                        q_nxt     = shadow_nxt;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_nxt  = SHIFT;
                    cnt_nxt    = '0;
                    shadow_nxt = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt  = IDLE;
                cnt_nxt    = '0;
                shadow_nxt = '0;
            end
        endcase
    end

    assign bus.q    = q;
    assign bus.qb   = ~q;
    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);
endmodule

// File: tb/tb_dff_shift_ctrl.sv
// Randomised bench for dff_shift_ctrl: frames are modelled as whole words and
// a monitor pops the expected word whenever the DUT raises done.
module tb_dff_shift_ctrl;
    localparam int WIDTH = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    dff_shift_ctrl_if #(.WIDTH(WIDTH)) bus ();
    dff_shift_ctrl #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] hold_q  = '0;
    logic [WIDTH-1:0] model_q = '0;
    logic [WIDTH-1:0] inv_q;
    bit mon_en    = 1'b0;
    bit rst_edge  = 1'b0;
    bit prev_done = 1'b0;
    int busy_run  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Remember whether the last edge was a reset edge so the monitor can clear its model.
    always @(posedge clk) rst_edge = !rstn;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_edge) begin
                hold_q   = '0;
                busy_run = 0;
            end
            inv_q = ~bus.q;
            chk("qb_is_not_q", 32'(bus.qb), 32'(inv_q));
            chk("busy_and_done", 32'(bus.busy & bus.done), 32'd0);
            if (bus.done) begin
                chk("done_one_cycle", 32'(prev_done), 32'd0);
                chk("busy_len", 32'(busy_run), 32'(WIDTH));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: actual=1 expected=0 at %0t", $time);
                end else begin
                    hold_q = exp_q.pop_front();
                    chk("q_frame", 32'(bus.q), 32'(hold_q));
                end
                busy_run = 0;
            end else begin
                chk("q_hold", 32'(bus.q), 32'(hold_q));
                busy_run = bus.busy ? busy_run + 1 : 0;
            end
            prev_done = bus.done;
        end
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            rstn      = 1'b1;
            bus.start = 1'b0;
            bus.abort = 1'($urandom_range(0, 1));
            bus.d     = 1'($urandom_range(0, 1));
            tick();
            chk("idle_busy", 32'(bus.busy), 32'd0);
            chk("idle_done", 32'(bus.done), 32'd0);
            chk("idle_q", 32'(bus.q), 32'(model_q));
        end
        bus.abort = 1'b0;
    endtask

    // ab_idx / rs_idx: bit position at which abort / reset is asserted (>= WIDTH means never).
    task automatic run_frame(input logic [WIDTH-1:0] bits, input int ab_idx,
                             input int rs_idx, input bit toggle_start);
        rstn      = 1'b1;
        bus.start = 1'b1;
        bus.abort = 1'($urandom_range(0, 1));
        bus.d     = 1'($urandom_range(0, 1));
        tick();
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        chk("done_after_start", 32'(bus.done), 32'd0);
        for (int i = 0; i < WIDTH; i++) begin
            bus.d     = bits[i];
            bus.start = toggle_start ? ((i % 2) == 0) : 1'b0;
            bus.abort = (i == ab_idx);
            rstn      = !(i == rs_idx);
            if (i == WIDTH - 1 && i != ab_idx && i != rs_idx)
                exp_q.push_back(bits);
            tick();
            if (i == ab_idx || i == rs_idx) break;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        rstn      = 1'b1;
        if (rs_idx < WIDTH) begin
            model_q = '0;
            chk("rst_q", 32'(bus.q), 32'd0);
            chk("rst_qb", 32'(bus.qb), 32'(WIDTH'('1)));
            chk("rst_busy", 32'(bus.busy), 32'd0);
            chk("rst_done", 32'(bus.done), 32'd0);
        end else if (ab_idx < WIDTH) begin
            chk("abort_busy", 32'(bus.busy), 32'd0);
            chk("abort_done", 32'(bus.done), 32'd0);
            chk("abort_q", 32'(bus.q), 32'(model_q));
        end else begin
            model_q = bits;
            chk("end_done", 32'(bus.done), 32'd1);
            chk("end_busy", 32'(bus.busy), 32'd0);
            chk("end_q", 32'(bus.q), 32'(bits));
        end
    endtask

    initial begin
        logic [WIDTH-1:0] bits;
        int r, ab, rs;

        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.d     = 1'b1;
        rstn      = 1'b0;
        tick();
        mon_en = 1'b1;
        tick();
        chk("reset_q", 32'(bus.q), 32'd0);
        chk("reset_qb", 32'(bus.qb), 32'(WIDTH'('1)));
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);

        // Release reset without start, with abort high: nothing may happen.
        rstn      = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b1;
        tick();
        chk("release_busy", 32'(bus.busy), 32'd0);
        chk("release_done", 32'(bus.done), 32'd0);
        bus.abort = 1'b0;

        run_frame(8'hA5, 99, 99, 1'b0);
        chk("basic_qb", 32'(bus.qb), 32'h5A);
        run_frame(8'h3C, 99, 99, 1'b1);
        idle(2);
        run_frame(8'hA5, 99, 99, 1'b0);
        idle(1);
        run_frame(8'hFF, 4, 99, 1'b0);
        chk("abort5_q", 32'(bus.q), 32'hA5);
        run_frame(8'h00, 7, 99, 1'b0);
        chk("abort8_q", 32'(bus.q), 32'hA5);
        idle(1);
        run_frame(8'h77, 99, 2, 1'b0);
        idle(1);

        for (int n = 0; n < 150; n++) begin
            bits = WIDTH'($urandom);
            r    = int'($urandom_range(0, 9));
            ab   = (r < 2)  ? int'($urandom_range(0, WIDTH - 1)) : 99;
            rs   = (r == 2) ? int'($urandom_range(0, WIDTH - 1)) : 99;
            run_frame(bits, ab, rs, 1'($urandom_range(0, 1)));
            idle(int'($urandom_range(0, 2)));
        end

        idle(3);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
